// File: rtl/dfmul_serial.sv
// Digit-serial BCD multiplier: MSD-first over the multiplier, shift the partial product one digit
// then add the multiplicand once per unit of that digit. Shares the divider's ld/done handshake.
module dfmul_serial #(
  parameter int unsigned N = 33
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [4*N-1:0] a,
  input  logic [4*N-1:0] b,
  output logic [8*N-1:0] p,
  output logic           done,
  output logic           err,
  output logic [7:0]     lzcnt
);

  localparam int ND = 2 * N;

  typedef enum logic [1:0] {StIdle, StShift, StAddn, StDone} state_e;

  state_e         state_q, state_d;
  logic [4*N-1:0] ai_q, bi_q;
  logic [8*N-1:0] pi_q, sum;
  logic [3:0]     cnt_q;
  logic [7:0]     dcnt_q;
  logic           bad_in;
  logic           shift_en, add_en, dec_en, fin_en;

  // Decimal add over 2N digits, multiplicand zero-extended; top carry dropped.
  always_comb begin
    logic [8*N-1:0] aext;
    logic [4:0]     dsum;
    logic           carry;
    aext  = {{(4*N){1'b0}}, ai_q};
    sum   = '0;
    dsum  = '0;
    carry = 1'b0;
    for (int i = 0; i < ND; i++) begin
      dsum = {1'b0, pi_q[4*i +: 4]} + {1'b0, aext[4*i +: 4]} + {4'b0, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = dsum[3:0];
    end
  end

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  always_comb begin
    logic found;
    lzcnt = '0;
    found = 1'b0;
    for (int i = ND - 1; i >= 0; i--) begin
      if (!found) begin
        if (p[4*i +: 4] == 4'd0) lzcnt = lzcnt + 8'd1;
        else found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; ld restarts from any state
  always_comb begin
    state_d = state_q;
    if (ld) begin
      state_d = StShift;
    end else begin
      unique case (state_q)
        StShift: state_d = StAddn;
        StAddn: begin
          if (cnt_q == 4'd0) state_d = (dcnt_q == 8'd0) ? StDone : StShift;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath strobes
  always_comb begin
    shift_en = 1'b0;
    add_en   = 1'b0;
    dec_en   = 1'b0;
    fin_en   = 1'b0;
    if (!ld) begin
      unique case (state_q)
        StShift: shift_en = 1'b1;
        StAddn: begin
          add_en = (cnt_q != 4'd0);
          dec_en = (cnt_q == 4'd0) && (dcnt_q != 8'd0);
        end
        StDone:  fin_en = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ai_q   <= '0;
      bi_q   <= '0;
      pi_q   <= '0;
      cnt_q  <= '0;
      dcnt_q <= '0;
      p      <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else if (ld) begin
      ai_q   <= a;
      bi_q   <= b;
      pi_q   <= '0;
      cnt_q  <= '0;
      dcnt_q <= 8'(N - 1);
      done   <= 1'b0;
      err    <= bad_in;
    end else begin
      if (shift_en) begin
        pi_q  <= pi_q << 4;
        bi_q  <= bi_q << 4;
        cnt_q <= bi_q[4*N-1 -: 4];
      end
      if (add_en) begin
        pi_q  <= sum;
        cnt_q <= cnt_q - 4'd1;
      end
      if (dec_en) dcnt_q <= dcnt_q - 8'd1;
      if (fin_en) begin
        p    <= pi_q;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dfmul_serial.sv
// Bench for dfmul_serial at N=4: directed and random products checked against an integer model.
module tb_dfmul_serial;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ld  = 1'b0;
  logic [W-1:0]   a   = '0;
  logic [W-1:0]   b   = '0;
  logic [2*W-1:0] p;
  logic           done;
  logic           err;
  logic [7:0]     lzcnt;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] p_prev = '0;

  dfmul_serial #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .a     (a),
    .b     (b),
    .p     (p),
    .done  (done),
    .err   (err),
    .lzcnt (lzcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint bcd2int(input logic [W-1:0] x);
    longint v = 0;
    for (int i = N - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [2*W-1:0] int2bcd(input longint v);
    logic [2*W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < 2 * N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int ref_lz(input longint v);
    int nd = 0;
    longint t = v;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    return 2 * N - nd;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] bb);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(bb[4*i +: 4]);
    return 2 * N + s + 1;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic r = 1'b0;
    for (int i = 0; i < N; i++) if (aa[4*i +: 4] > 4'd9 || bb[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle ld pulse; returns just after the ld edge.
  task automatic start_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    a  = aa;
    b  = bb;
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    chk({tag, " done_low"}, 64'(done), 64'd0);
    chk({tag, " err"}, 64'(err), 64'(has_bad(aa, bb)));
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic check_p);
    int k;
    logic held = 1'b1;
    longint prod = bcd2int(aa) * bcd2int(bb);
    for (k = 1; k <= 11 * N + 5; k++) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (p !== p_prev) held = 1'b0;
    end
    chk({tag, " latency"}, 64'(k), 64'(ref_lat(bb)));
    chk({tag, " p_held"}, 64'(held), 64'd1);
    chk({tag, " err_at_done"}, 64'(err), 64'(has_bad(aa, bb)));
    if (check_p) begin
      chk({tag, " p"}, 64'(p), 64'(int2bcd(prod)));
      chk({tag, " lzcnt"}, 64'(lzcnt), 64'(ref_lz(prod)));
      p_prev = int2bcd(prod);
    end else begin
      p_prev = p;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb);
    start_op(tag, aa, bb);
    finish_op(tag, aa, bb, !has_bad(aa, bb));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic held;

    #2;
    chk("reset p", 64'(p), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset lzcnt", 64'(lzcnt), 64'(2 * N));
    @(negedge clk);
    rst = 1'b0;

    run_op("1234x2", 16'h1234, 16'h0002);
    run_op("9999x9999", 16'h9999, 16'h9999);
    run_op("5000x0", 16'h5000, 16'h0000);

    // Restart mid-operation: second ld lands on edge 10 of the first.
    start_op("restart_a", 16'h9999, 16'h9999);
    held = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || p !== p_prev) held = 1'b0;
    end
    chk("restart quiet", 64'(held), 64'd1);
    run_op("restart_b", 16'h0003, 16'h0007);

    // Asynchronous reset between edges while adding; invalid digit so err is set beforehand.
    start_op("areset", 16'h1A34, 16'h0500);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("areset p", 64'(p), 64'd0);
    chk("areset done", 64'(done), 64'd0);
    chk("areset err", 64'(err), 64'd0);
    chk("areset lzcnt", 64'(lzcnt), 64'(2 * N));
    p_prev = '0;
    #2;
    rst = 1'b0;
    run_op("post_reset", 16'h0042, 16'h0310);

    run_op("bad_digit", 16'h00A1, 16'h0001);
    run_op("valid_after_bad", 16'h0101, 16'h0011);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if (t < 4) ra = ra & 16'h00FF;
      run_op($sformatf("rand%0d", t), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
